onchip_mem_copy_master: RTL
===========================

Name: onchip_mem_copy_master

Overview:
Avalon-MM initiator that drives the single-port on-chip memory slave (13-bit word address, 32-bit data, byte enables, fixed 1-cycle read latency, no waitrequest). It accepts copy commands and moves blocks of words from a source region to a destination region in the same memory. Typical use is staging CORDIC operand and result buffers without Nios II CPU load. It owns the memory port while busy; any arbitration sits outside this block.

Parameters:
ADDR_W, 13, memory word-address width
DATA_W, 32, data width; byteenable width is DATA_W/8
DEPTH, 6050, number of valid memory words; used for range checks
LEN_W, 14, width of the length field in words

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid & cmd_ready
cmd_src  in  ADDR_W  source start word address
cmd_dst  in  ADDR_W  destination start word address
cmd_len  in  LEN_W  number of words to copy
busy  out  1  high from accept until done/error
done  out  1  1-cycle pulse, copy complete
error  out  1  1-cycle pulse, command rejected by range check
address  out  ADDR_W  memory address
byteenable  out  DATA_W/8  always all-ones during accesses, 0 otherwise
chipselect  out  1  memory select
write  out  1  memory write strobe
writedata  out  DATA_W  memory write data
readdata  in  DATA_W  memory read data, valid 1 cycle after the read cycle
clken  out  1  memory clock enable, tied 1

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state IDLE; busy, done, error, chipselect, write = 0; address, writedata, byteenable = 0; counters cleared; clken = 1. A reset mid-copy aborts at the next edge with no done pulse. Words already written stay written.
- FSM states: IDLE, CHECK, RD, CAP, WR, FIN.
- IDLE: cmd_ready = 1. On accept, latch src, dst and len, set busy, and go to CHECK.
- CHECK, 1 cycle, no bus activity:
  - If src+len > DEPTH or dst+len > DEPTH (computed at LEN_W+1 bits, no wrap), go to FIN with error.
  - Else if len == 0, go to FIN with done.
  - Else go to RD.
- RD: chipselect = 1, write = 0, address = src+idx, byteenable = all-ones. Go to CAP.
- CAP: chipselect = 0. Register readdata into a data register. Go to WR.
- WR: chipselect = 1, write = 1, address = dst+idx, writedata = data register. Increment idx. If idx+1 == len, go to FIN with done; else go to RD.
- FIN: pulse done or error (exactly one) for 1 cycle, clear busy, go to IDLE. cmd_ready returns the following cycle.
- Throughput is 3 cycles per word. For len = N, done is asserted exactly 3N+2 cycles after the accept edge.
- Overlapping regions: the copy is strictly ascending, one word read then written. With dst > src and overlap, the source pattern propagates forward (defined behaviour, not an error).
- cmd inputs are ignored while busy. A new command can be accepted the cycle after the done/error pulse.
- All outputs are registered.

Optional Feature:
Macro COPY_CHECKSUM_EN.
- With the macro defined: adds output checksum[DATA_W-1:0]. It holds the modulo-2^DATA_W sum of all words captured in CAP, is cleared on command accept and on reset, and is valid when done pulses. On error it reads 0.
- Without the macro: the port and adder are absent; everything else is identical.

Decomposition:
- Package onchip_mem_copy_pkg holds:
  - the state enum (IDLE, CHECK, RD, CAP, WR, FIN)
  - ADDR_W, DATA_W and DEPTH default constants
  - a BE_ALL constant
- No sub-module; a single FSM plus datapath. The bench supplies a behavioural 1-cycle-latency RAM model.

Test Plan:
- Preload mem[0..3] = 0x11,0x22,0x33,0x44; cmd src=0, dst=100, len=4 -> mem[100..103] match; done pulses 14 cycles after accept; exactly 4 reads and 4 writes.
- cmd len=0, src=5, dst=5 -> done 2 cycles after accept; chipselect never asserted; error stays 0.
- cmd src=6000, dst=0, len=51 -> error pulse, no done, no memory access. Also src=6000, len=50 -> accepted, completes normally.
- Overlap: mem[10..12] = A,B,C; cmd src=10, dst=11, len=2 -> mem[11] = A, mem[12] = A.
- Assert reset during WR of word 2 of an 8-word copy -> next cycle chipselect = 0, busy = 0, no done; a subsequent command runs correctly.
- With COPY_CHECKSUM_EN: copy 0xFFFFFFFF,0x00000002 -> checksum = 0x00000001 at done. Without the macro, the bench compiles with no checksum port.

Source files
------------

// File: rtl/onchip_mem_copy_pkg.sv
// onchip_mem_copy_pkg
// Shared definitions for the on-chip memory copy initiator:
//   - default geometry of the on-chip memory slave (address/data width, depth)
//   - default width of the copy length field
//   - BE_ALL: all-ones byte-enable mask. It is wider than any supported bus,
//     so users slice it down to DATA_W/8 bits.
//   - state_e: copy engine states
package onchip_mem_copy_pkg;

  localparam int unsigned DEF_ADDR_W = 13;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 6050;
  localparam int unsigned DEF_LEN_W  = 14;

  localparam logic [127:0] BE_ALL = '1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD,
    CAP,
    WR,
    FIN
  } state_e;

endpackage

// File: rtl/onchip_mem_copy_master.sv
// onchip_mem_copy_master
// Avalon-MM initiator that copies blocks of words inside one single-port
// on-chip memory. The memory has a fixed 1-cycle read latency and no
// waitrequest. Each word takes 3 cycles: read, capture, write. Copies run in
// ascending address order, so when the regions overlap forward the source
// pattern propagates (defined behaviour).
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake. cmd_ready is high only while idle.
//   cmd_src/dst/len     : source and destination start word addresses, length in words
//   busy                : high from command accept until the done/error pulse
//   done / error        : 1-cycle completion / range-reject pulses
//   address, byteenable, chipselect, write, writedata, readdata, clken :
//                         memory port. clken is tied high.
//   checksum            : only present when COPY_CHECKSUM_EN is defined. It is
//                         the sum modulo 2^DATA_W of every word read by the
//                         current command.
//
// Build option: define COPY_CHECKSUM_EN to add the checksum output and adder.
module onchip_mem_copy_master
  import onchip_mem_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_src,
  input  logic [ADDR_W-1:0]     cmd_dst,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W-1:0]     readdata,
  output logic                  clken
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     checksum
`endif
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned SUM_W = LEN_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic                err_q, err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [BE_W-1:0]     byteenable_q, byteenable_d;
  logic                chipselect_q, chipselect_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
`ifdef COPY_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

  // Region end addresses, one bit wider than the length so they cannot wrap.
  logic [SUM_W-1:0]    src_end, dst_end;
  logic [LEN_W-1:0]    idx_next;
  logic                range_bad;

  assign src_end   = SUM_W'(src_q) + SUM_W'(len_q);
  assign dst_end   = SUM_W'(dst_q) + SUM_W'(len_q);
  assign range_bad = (src_end > SUM_W'(DEPTH)) || (dst_end > SUM_W'(DEPTH));
  assign idx_next  = idx_q + LEN_W'(1);

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    idx_d        = idx_q;
    err_d        = err_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    address_d    = '0;
    byteenable_d = '0;
    chipselect_d = 1'b0;
    write_d      = 1'b0;
    writedata_d  = writedata_q;
`ifdef COPY_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    // The bus outputs are computed for the state being entered, so the
    // registered strobes line up with the state they belong to.
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          len_d   = cmd_len;
          idx_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef COPY_CHECKSUM_EN
          checksum_d = '0;
`endif
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (range_bad) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (len_q == '0) begin
          state_d = FIN;
        end else begin
          state_d      = RD;
          chipselect_d = 1'b1;
          address_d    = src_q;
          byteenable_d = BE_ALL[BE_W-1:0];
        end
      end

      RD: begin
        state_d = CAP;
      end

      CAP: begin
        // readdata belongs to the read issued in RD; writedata doubles as
        // the data holding register for the following write.
        writedata_d  = readdata;
`ifdef COPY_CHECKSUM_EN
        checksum_d   = checksum_q + readdata;
`endif
        state_d      = WR;
        chipselect_d = 1'b1;
        write_d      = 1'b1;
        address_d    = dst_q + ADDR_W'(idx_q);
        byteenable_d = BE_ALL[BE_W-1:0];
      end

      WR: begin
        idx_d = idx_next;
        if (idx_next == len_q) begin
          state_d = FIN;
        end else begin
          state_d      = RD;
          chipselect_d = 1'b1;
          address_d    = src_q + ADDR_W'(idx_next);
          byteenable_d = BE_ALL[BE_W-1:0];
        end
      end

      FIN: begin
        done_d  = ~err_q;
        error_d = err_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready only when idle now and staying idle. This keeps cmd_ready low
  // during the done/error pulse and during the cycle after an accept.
  assign cmd_ready_d = (state_q == IDLE) && (state_d == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      address_q    <= '0;
      byteenable_q <= '0;
      chipselect_q <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
`ifdef COPY_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      chipselect_q <= chipselect_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
`ifdef COPY_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign chipselect = chipselect_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign clken      = 1'b1;
`ifdef COPY_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule
